// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared PCM types, frame constants and the 16-bit saturation helper
package audio_pkg;

  typedef logic signed [15:0] pcm16_t;

  localparam int I2S_BITS_PER_FRAME = 32;

  localparam int PCM16_MAX = 32767;
  localparam int PCM16_MIN = -32768;

  // Clamp a signed 32-bit value into the 16-bit PCM range.
  function automatic pcm16_t sat16(input logic signed [31:0] s);
    if (s > PCM16_MAX) begin
      return pcm16_t'(PCM16_MAX);
    end else if (s < PCM16_MIN) begin
      return pcm16_t'(PCM16_MIN);
    end else begin
      return s[15:0];
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - show-ahead synchronous FIFO with occupancy count
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr, wr_data     : write strobe and data (accepted when not full, or when a read frees a slot)
//   rd, rd_data     : read strobe and head word (valid whenever not empty)
//   full, empty     : status
//   level           : current occupancy
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  assign rd_ok = rd & ~empty;
  // A read in the same cycle frees the slot the write needs.
  assign wr_ok = wr & (~full | rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/psola_i2s_tx.sv
// rtl/psola_i2s_tx.sv - scale/saturate PSOLA samples, buffer them, and serialise as mono-duplicated I2S
//   clk_in, rst_n_in          : system clock, asynchronous active-low reset
//   audio_in, audio_valid_in  : 32-bit signed sample and its single-cycle strobe
//   bclk_out, lrclk_out       : I2S bit clock and word select (0 = left)
//   sdata_out                 : serial data, MSB first, changes with BCLK falling
//   fifo_level_out            : sample FIFO occupancy
//   overflow_out              : sticky, a write was dropped on a full FIFO
//   underflow_out             : sticky, a frame started with the FIFO empty
module psola_i2s_tx
  import audio_pkg::*;
#(
  parameter int SHIFT      = 8,
  parameter int BCLK_HALF  = 36,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [31:0]                   audio_in,
  input  logic                          audio_valid_in,
  output logic                          bclk_out,
  output logic                          lrclk_out,
  output logic                          sdata_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  output logic                          underflow_out
);

  localparam int HC_W = $clog2(BCLK_HALF);
  localparam int BI_W = $clog2(I2S_BITS_PER_FRAME);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(BCLK_HALF - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(I2S_BITS_PER_FRAME - 1);
  localparam logic [BI_W-1:0] BI_HALF = BI_W'(I2S_BITS_PER_FRAME / 2);

  // Scale stage
  logic signed [31:0] shifted;
  pcm16_t             word_q;
  logic               word_valid_q;

  assign shifted = $signed(audio_in) >>> SHIFT;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_q       <= sat16(shifted);
      word_valid_q <= audio_valid_in;
    end
  end

  // Bit clock generator
  logic [HC_W-1:0] hc;
  logic            hc_wrap;
  logic            fall;

  assign hc_wrap = (hc == HC_LAST);
  assign fall    = hc_wrap & bclk_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hc       <= '0;
      bclk_out <= 1'b0;
    end else if (hc_wrap) begin
      hc       <= '0;
      bclk_out <= ~bclk_out;
    end else begin
      hc       <= hc + HC_W'(1);
    end
  end

  // Bit index and frame start
  logic [BI_W-1:0] bi;
  logic [BI_W-1:0] bi_next;
  logic            frame_start;

  assign bi_next     = bi + BI_W'(1);
  assign frame_start = fall & (bi == BI_LAST);

  // Sample FIFO
  pcm16_t                       head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         pop;
  pcm16_t                       cur;

  assign pop = frame_start & ~fifo_empty;
  assign cur = fifo_empty ? pcm16_t'(0) : head;

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .wr      (word_valid_q),
    .wr_data (word_q),
    .rd      (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_out)
  );

  // Serializer: the frame-start edge still emits the old sr[31], i.e. the
  // previous right word's LSB, giving the one-BCLK Philips delay.
  logic [31:0] sr;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bi        <= BI_LAST;
      sr        <= '0;
      sdata_out <= 1'b0;
      lrclk_out <= 1'b0;
    end else if (fall) begin
      bi        <= bi_next;
      sdata_out <= sr[31];
      lrclk_out <= (bi_next >= BI_HALF);
      sr        <= frame_start ? {cur, cur} : {sr[30:0], 1'b0};
    end
  end

  // Sticky status
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (word_valid_q & fifo_full & ~pop) overflow_out  <= 1'b1;
      if (frame_start & fifo_empty)        underflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psola_i2s_tx.sv
// tb/tb_psola_i2s_tx.sv - randomized self-checking bench for psola_i2s_tx
module tb_psola_i2s_tx;

  localparam int SHIFT      = 8;
  localparam int BCLK_HALF  = 36;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CYC    = 2 * BCLK_HALF;
  localparam int FRAME_CYC  = 32 * BIT_CYC;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] audio_in;
  logic        audio_valid_in;
  logic        bclk_out;
  logic        lrclk_out;
  logic        sdata_out;
  logic [2:0]  fifo_level_out;
  logic        overflow_out;
  logic        underflow_out;

  always #5 clk_in = ~clk_in;

  psola_i2s_tx #(
    .SHIFT      (SHIFT),
    .BCLK_HALF  (BCLK_HALF),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .audio_in       (audio_in),
    .audio_valid_in (audio_valid_in),
    .bclk_out       (bclk_out),
    .lrclk_out      (lrclk_out),
    .sdata_out      (sdata_out),
    .fifo_level_out (fifo_level_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: edge count since reset release, queue of stored words,
  // and the word currently being transmitted.
  int          n;
  logic [15:0] q[$];
  logic [15:0] cur_word;
  logic        pend_v;
  logic [15:0] pend_w;
  logic        m_ovf, m_uf;
  logic        e_sdata, e_lr, e_bclk;
  int          burst;

  function automatic logic [15:0] sat_ref(input logic [31:0] a);
    longint s;
    s = longint'($signed(a));
    s = s >>> SHIFT;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic model_reset();
    n = 0; q.delete(); cur_word = '0; pend_v = 1'b0; pend_w = '0;
    m_ovf = 1'b0; m_uf = 1'b0; e_sdata = 1'b0; e_lr = 1'b0; e_bclk = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] a);
    int j;
    n++;
    if (n % BIT_CYC == 0) begin
      j = ((n / BIT_CYC) - 1) % 32;
      if (j == 0) begin
        e_sdata = cur_word[0];
        if (q.size() > 0) cur_word = q.pop_front();
        else begin cur_word = '0; m_uf = 1'b1; end
      end else if (j <= 16) begin
        e_sdata = cur_word[16-j];
      end else begin
        e_sdata = cur_word[32-j];
      end
      e_lr = (j >= 16);
    end
    if (pend_v) begin
      if (q.size() < FIFO_DEPTH) q.push_back(pend_w);
      else m_ovf = 1'b1;
    end
    pend_v = v;
    pend_w = sat_ref(a);
    e_bclk = ((n / BCLK_HALF) % 2) == 1;
  endtask

  task automatic check_outputs();
    expect_eq("bclk",      {31'd0, bclk_out},      {31'd0, e_bclk});
    expect_eq("lrclk",     {31'd0, lrclk_out},     {31'd0, e_lr});
    expect_eq("sdata",     {31'd0, sdata_out},     {31'd0, e_sdata});
    expect_eq("level",     {29'd0, fifo_level_out}, q.size());
    expect_eq("overflow",  {31'd0, overflow_out},  {31'd0, m_ovf});
    expect_eq("underflow", {31'd0, underflow_out}, {31'd0, m_uf});
  endtask

  function automatic logic [31:0] pick_audio();
    logic [31:0] special [6];
    logic [31:0] r;
    special = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_2300,
                32'h007F_FF00, 32'hFF80_0000, 32'h0000_0000};
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return special[$urandom_range(0, 5)];
      1:       return {{8{r[23]}}, r[23:0]};
      2:       return r;
      default: return 32'h007F_FF00 + 32'($urandom_range(0, 511)) - 32'd256;
    endcase
  endfunction

  // mode 0: idle, mode 1: sparse random writes with bursts, mode 2: directed burst then sparse
  task automatic run(input int mode, input int cycles);
    logic [31:0] dir [5];
    logic        v;
    logic [31:0] a;
    dir = '{32'hFFA5_C300, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_2300, 32'h1234_5678};
    burst = 0;
    for (int i = 0; i < cycles; i++) begin
      check_outputs();
      v = 1'b0;
      a = $urandom;
      if (mode == 2 && i >= 3 && i <= 11) begin
        if (i % 2 == 1) begin v = 1'b1; a = dir[(i-3)/2]; end
      end else if (mode == 1) begin
        if (burst == 0 && (i == 100 || $urandom_range(0, 7999) == 0)) burst = 5;
        if (burst > 0) begin
          if (i % 2 == 0) begin v = 1'b1; burst--; end
        end else begin
          v = ($urandom_range(0, 1999) == 0);
        end
        if (v) a = pick_audio();
      end else if (mode == 2 && i > 3000) begin
        v = ($urandom_range(0, 1999) == 0);
        if (v) a = pick_audio();
      end
      audio_valid_in = v;
      audio_in       = a;
      @(posedge clk_in);
      model_edge(v, a);
      @(negedge clk_in);
    end
  endtask

  initial begin
    rst_n_in       = 1'b0;
    audio_valid_in = 1'b0;
    audio_in       = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_outputs();

    // No writes: silent output, underflow from the first frame start.
    rst_n_in = 1'b1;
    run(0, 4 * FRAME_CYC);

    rst_n_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    // Random traffic, stopping partway through a frame (just after bit 20).
    run(1, 9 * FRAME_CYC + 21 * BIT_CYC + 10);

    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    expect_eq("async_bclk",  {31'd0, bclk_out},       32'd0);
    expect_eq("async_lrclk", {31'd0, lrclk_out},      32'd0);
    expect_eq("async_sdata", {31'd0, sdata_out},      32'd0);
    expect_eq("async_level", {29'd0, fifo_level_out}, 32'd0);
    expect_eq("async_ovf",   {31'd0, overflow_out},   32'd0);
    expect_eq("async_uf",    {31'd0, underflow_out},  32'd0);
    model_reset();
    audio_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    // 0xA5C3 first, then saturation words; the fifth write overflows.
    run(2, 4 * FRAME_CYC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psola_i2s_tx.md
# psola_i2s_tx

Output stage directly downstream of the PSOLA bufferizer: consumes its 32-bit signed audio words, scales and saturates them to 16 bits, and queues them in a small FIFO. It also serialises them onto a free-running mono-duplicated I2S link (Philips format) for the board DAC. The frame rate is derived from the system clock so that one I2S frame spans exactly one bufferizer sample period (2304 cycles).

## Interface
- `SHIFT`, 8: arithmetic right shift applied to `audio_in` before saturation.
- `BCLK_HALF`, 36: system-clock cycles per BCLK half-period; frame = 64·`BCLK_HALF` cycles (2304).
- `FIFO_DEPTH`, 4: sample FIFO entries (power of two).
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: one clock; reset is asynchronous and active-low.
- `audio_in` input 32: signed PSOLA sample.
- `audio_valid_in` input 1: single-cycle strobe qualifying `audio_in`.
- `bclk_out` output 1: I2S bit clock.
- `lrclk_out` output 1: word select; 0 = left, 1 = right.
- `sdata_out` output 1: serial data, MSB first, changes on BCLK falling edge.
- `fifo_level_out` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow_out` output 1: sticky; a write was dropped because the FIFO was full.
- `underflow_out` output 1: sticky; a frame started with the FIFO empty.

## Operation
- Scale stage, registered: `s = audio_in >>> SHIFT` (signed). Clamp `s` to [-32768, 32767] to form a 16-bit word.
- Write: the scaled word is written one cycle after `audio_valid_in`. If the FIFO is full, the word is dropped and `overflow_out` is set.
- Half-period counter `hc` runs 0..`BCLK_HALF`-1. At `hc == BCLK_HALF-1` it wraps and `bclk_out` toggles. A 1→0 transition is a *fall event*.
- Bit index `bi` runs 0..31 and advances on each fall event. Reset value of `bi` is 31, so the first fall event is a frame start.
- Frame start is the fall event on which `bi` wraps 31→0:
  - pop the FIFO head into `cur`;
  - if the FIFO is empty, `cur` = 0 and `underflow_out` is set;
  - load shift register `sr[31:0] = {cur, cur}`;
  - on the same edge, `sdata_out` takes the old `sr[31]`, which is the previous frame's right-channel LSB.
- Every other fall event: `sdata_out <= sr[31]`, `sr <= sr << 1`.
- `lrclk_out` is updated on fall events: 0 when the new `bi` is 0..15, 1 when it is 16..31. This places each word's MSB one BCLK after the LRCLK edge.
- Simultaneous write and pop in the same cycle: both take effect and the level is unchanged. When the FIFO is full, a simultaneous pop frees a slot, so the write is accepted.
- Sticky flags clear only on reset.

## Timing
- Reset values, all asserted while `rst_n_in` is low:
  - `bclk_out`, `lrclk_out`, `sdata_out` = 0;
  - `fifo_level_out` = 0; `overflow_out` = `underflow_out` = 0;
  - `hc` = 0, `bi` = 31, `sr` = 0.
- Reset mid-frame aborts the frame immediately and discards FIFO contents.
- First fall event occurs `2·BCLK_HALF` cycles after reset release (cycle 72). The first frame carries zeros.
- Pipeline latency:
  - `audio_valid_in` at cycle t → `fifo_level_out` increments at t+2.
  - A pop at a frame start drives the word's MSB on `sdata_out` at the next fall event (+72 cycles).
- Frame period is exactly 64·`BCLK_HALF` cycles with no drift. `sdata_out` and `lrclk_out` change only on the same clock edge that drops `bclk_out`.

## Structure
- Package `audio_pkg`:
  - `typedef logic signed [15:0] pcm16_t`;
  - `localparam I2S_BITS_PER_FRAME = 32`;
  - saturation limits `PCM16_MAX` and `PCM16_MIN`.
- Sub-module `sample_fifo`:
  - synchronous FIFO parameterised by width and depth;
  - ports: write and read strobes, `full`, `empty`, `level`;
  - async active-low reset;
  - reads are show-ahead, so the head is valid whenever the FIFO is not empty.
- Top level holds the scale/saturate register, the BCLK/LRCLK generator and the shift register.

## Test plan
- Saturation: with `SHIFT`=8, inputs 0x7FFF_FFFF, 0x8000_0000 and 0x0001_2300 → words 0x7FFF, 0x8000 and 0x0123.
- Serial format: write 0xA5C3 before the first frame start → left slot bits 1..16 and right slot bits 17..31 plus bit 0 of the next frame each read 1010_0101_1100_0011 MSB first. `lrclk_out` falls at bit 0 and rises at bit 16.
- Clock ratios: BCLK period is 72 cycles, LRCLK period is 2304 cycles, measured over 10 frames with zero drift.
- Underflow: no writes after reset → `sdata_out` stays 0. `underflow_out` rises at cycle 72 and remains set.
- Overflow: 5 writes within 10 cycles before any frame start → `fifo_level_out` = 4 and `overflow_out` = 1. The first four words are transmitted in order.
- Async reset: assert `rst_n_in` mid-frame at bit 20 → all outputs go 0 without waiting for a clock. After release, the first fall event arrives 72 cycles later.
